// File: rtl/core_config.sv
// Shared type and encoding definitions for the cache-side bus arbiter.
package core_config;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IC   = 2'd1,
    R_DC   = 2'd2
  } rd_arb_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_arb_state_t;

  localparam int unsigned TYPE_W = 3;

  localparam logic [TYPE_W-1:0] TYPE_BYTE = 3'd0;
  localparam logic [TYPE_W-1:0] TYPE_HALF = 3'd1;
  localparam logic [TYPE_W-1:0] TYPE_WORD = 3'd2;
  localparam logic [TYPE_W-1:0] TYPE_LINE = 3'd4;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Shares the cache-side memory bus between icache and dcache: one outstanding
// read, one outstanding write, with read-after-write line hazard blocking.
module cache_bus_arbiter
  import core_config::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned OFFS_W       = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [31:0]       ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [31:0]       dc_ret_data,
  input  logic              dc_wr_req,
  input  logic [2:0]        dc_wr_type,
  input  logic [ADDR_W-1:0] dc_wr_addr,
  input  logic [3:0]        dc_wr_wstrb,
  input  logic [LINE_W-1:0] dc_wr_data,
  output logic              dc_wr_rdy,
  output logic              bus_rd_req,
  output logic [2:0]        bus_rd_type,
  output logic [ADDR_W-1:0] bus_rd_addr,
  input  logic              bus_rd_rdy,
  input  logic              bus_ret_valid,
  input  logic              bus_ret_last,
  input  logic [31:0]       bus_ret_data,
  output logic              bus_wr_req,
  output logic [2:0]        bus_wr_type,
  output logic [ADDR_W-1:0] bus_wr_addr,
  output logic [3:0]        bus_wr_wstrb,
  output logic [LINE_W-1:0] bus_wr_data,
  input  logic              bus_wr_rdy,
  input  logic              bus_wr_done
);

  localparam int unsigned LA_W  = ADDR_W - OFFS_W;
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  rd_arb_state_t    rd_state, rd_state_nxt;
  wr_arb_state_t    wr_state, wr_state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic [LA_W-1:0]  wr_line, wr_line_nxt;
  logic             rd_lock, rd_lock_nxt;
  logic             lock_dc, lock_dc_nxt;

  logic [LA_W-1:0]  ic_line, dc_line, wr_req_line;
  logic             wr_hs, rd_hs;
  logic             ic_haz, dc_haz, ic_elig, dc_elig;
  logic             ic_win, dc_win;

  assign ic_line     = ic_rd_addr[ADDR_W-1:OFFS_W];
  assign dc_line     = dc_rd_addr[ADDR_W-1:OFFS_W];
  assign wr_req_line = dc_wr_addr[ADDR_W-1:OFFS_W];

  assign wr_hs = !rst && (wr_state == W_IDLE) && dc_wr_req && bus_wr_rdy;
  assign rd_hs = bus_rd_req && bus_rd_rdy;

  // A read must not overtake a write to the same line, in flight or accepted now.
  assign ic_haz = ((wr_state == W_BUSY) && (ic_line == wr_line)) ||
                  (wr_hs && (ic_line == wr_req_line));
  assign dc_haz = ((wr_state == W_BUSY) && (dc_line == wr_line)) ||
                  (wr_hs && (dc_line == wr_req_line));

  assign ic_elig = ic_rd_req && !ic_haz;
  assign dc_elig = dc_rd_req && !dc_haz;

  // Winner selection; an unaccepted bus request stays with its requester.
  always_comb begin
    ic_win = 1'b0;
    dc_win = 1'b0;
    if (rd_lock) begin
      ic_win = !lock_dc && ic_rd_req;
      dc_win = lock_dc && dc_rd_req;
    end else begin
      ic_win = ic_elig && (!dc_elig || (starve_cnt == STARVE_MAX));
      dc_win = dc_elig && !ic_win;
    end
  end

  // Combinational bus-side and cache-side outputs from registered state.
  always_comb begin
    bus_rd_req   = 1'b0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    bus_rd_type  = dc_win ? dc_rd_type : ic_rd_type;
    bus_rd_addr  = dc_win ? dc_rd_addr : ic_rd_addr;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    ic_ret_data  = bus_ret_data;
    dc_ret_data  = bus_ret_data;
    bus_wr_req   = 1'b0;
    dc_wr_rdy    = 1'b0;
    bus_wr_type  = dc_wr_type;
    bus_wr_addr  = dc_wr_addr;
    bus_wr_wstrb = dc_wr_wstrb;
    bus_wr_data  = dc_wr_data;
    if (!rst) begin
      if (rd_state == R_IDLE) begin
        bus_rd_req = ic_win || dc_win;
        ic_rd_rdy  = ic_win && bus_rd_rdy;
        dc_rd_rdy  = dc_win && bus_rd_rdy;
      end
      if (rd_state == R_IC) begin
        ic_ret_valid = bus_ret_valid;
        ic_ret_last  = bus_ret_valid && bus_ret_last;
      end
      if (rd_state == R_DC) begin
        dc_ret_valid = bus_ret_valid;
        dc_ret_last  = bus_ret_valid && bus_ret_last;
      end
      if (wr_state == W_IDLE) begin
        bus_wr_req = dc_wr_req;
        dc_wr_rdy  = bus_wr_rdy;
      end
    end
  end

  // Next-state logic for both FSMs, starvation counter and grant lock.
  always_comb begin
    rd_state_nxt   = rd_state;
    wr_state_nxt   = wr_state;
    starve_cnt_nxt = starve_cnt;
    wr_line_nxt    = wr_line;
    rd_lock_nxt    = 1'b0;
    lock_dc_nxt    = lock_dc;
    unique case (rd_state)
      R_IDLE: begin
        rd_lock_nxt = bus_rd_req && !bus_rd_rdy;
        lock_dc_nxt = dc_win;
        if (rd_hs) begin
          rd_state_nxt = ic_win ? R_IC : R_DC;
          if (ic_win) begin
            starve_cnt_nxt = '0;
          end else if (ic_rd_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end
      R_IC, R_DC: begin
        if (bus_ret_valid && bus_ret_last) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
    unique case (wr_state)
      W_IDLE: begin
        if (wr_hs) begin
          wr_state_nxt = W_BUSY;
          wr_line_nxt  = wr_req_line;
        end
      end
      W_BUSY: begin
        if (bus_wr_done) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= R_IDLE;
      wr_state   <= W_IDLE;
      starve_cnt <= '0;
      wr_line    <= '0;
      rd_lock    <= 1'b0;
      lock_dc    <= 1'b0;
    end else begin
      rd_state   <= rd_state_nxt;
      wr_state   <= wr_state_nxt;
      starve_cnt <= starve_cnt_nxt;
      wr_line    <= wr_line_nxt;
      rd_lock    <= rd_lock_nxt;
      lock_dc    <= lock_dc_nxt;
    end
  end

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Shares the single cache-side memory bus between the icache refill path and the dcache refill/uncached-load and writeback/uncached-store paths. The block sits between both caches and the AXI bridge built from `axi_read_channel`/`axi_write_channel`. It sequences one outstanding read and one outstanding write, and routes read returns back to the owning cache. It blocks any read that hits the line of an in-flight write, so a refill never returns stale data.

## Interface
Parameters:
- `ADDR_W`, 32, physical address width
- `LINE_W`, 128, cache line / write data width (4 words)
- `OFFS_W`, 4, byte-offset bits ignored by the line-address compare
- `STARVE_LIMIT`, 4, consecutive dcache read grants allowed while icache waits

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `ic_rd_req` / `dc_rd_req`  in  1  read request from icache / dcache
- `ic_rd_type` / `dc_rd_type`  in  3  0=byte, 1=half, 2=word, 4=line
- `ic_rd_addr` / `dc_rd_addr`  in  ADDR_W  read address
- `ic_rd_rdy` / `dc_rd_rdy`  out  1  read request accepted this cycle
- `ic_ret_valid` / `dc_ret_valid`, `ic_ret_last` / `dc_ret_last`  out  1  routed return beat / final beat
- `ic_ret_data` / `dc_ret_data`  out  32  routed return data
- `dc_wr_req`  in  1  write request (dcache only)
- `dc_wr_type`  in  3  same encoding as `rd_type`
- `dc_wr_addr`  in  ADDR_W  write address
- `dc_wr_wstrb`  in  4  byte strobe for non-line writes
- `dc_wr_data`  in  LINE_W  write data
- `dc_wr_rdy`  out  1  write accepted this cycle
- `bus_rd_req`, `bus_rd_type`, `bus_rd_addr`  out  1/3/ADDR_W  request to the bridge
- `bus_rd_rdy`  in  1  bridge read handshake
- `bus_ret_valid`, `bus_ret_last`  in  1  return beat / final beat
- `bus_ret_data`  in  32  return data
- `bus_wr_req`, `bus_wr_type`, `bus_wr_addr`, `bus_wr_wstrb`, `bus_wr_data`  out  request to the bridge
- `bus_wr_rdy`  in  1  bridge write handshake
- `bus_wr_done`  in  1  1-cycle pulse on AXI B response

## Operation
- Read FSM states: `R_IDLE`, `R_IC`, `R_DC`.
  - In `R_IDLE`, the winner is selected combinationally and its type/address drive the `bus_rd_*` outputs.
  - The bridge handshake is `bus_rd_req & bus_rd_rdy`. `bus_rd_rdy` is forwarded to the winner only.
  - On the handshake the FSM moves to `R_IC` or `R_DC`. It returns to `R_IDLE` on `bus_ret_valid & bus_ret_last`.
- Read priority: dcache wins over icache.
  - 3-bit `starve_cnt` increments on each dcache grant while `ic_rd_req` is high. It clears on any icache grant.
  - When `starve_cnt == STARVE_LIMIT`, icache wins.
- Write FSM states: `W_IDLE`, `W_BUSY`.
  - In `W_IDLE`, `dc_wr_*` is passed straight through to `bus_wr_*`, and `dc_wr_rdy = bus_wr_rdy`.
  - On the handshake, the line address `addr[ADDR_W-1:OFFS_W]` is latched into `wr_line` and the FSM goes to `W_BUSY`.
  - In `W_BUSY`, `bus_wr_req = 0` and `dc_wr_rdy = 0`. The FSM returns to `W_IDLE` on `bus_wr_done`.
- Read-after-write hazard: a candidate read is ineligible when its line matches either of these:
  - `wr_line` while in `W_BUSY`;
  - `dc_wr_addr` during a write handshake in the same cycle.

  An ineligible candidate is masked from arbitration, so the other requester may win. If neither requester is eligible, `bus_rd_req = 0`.
- Returns are routed by FSM state. The non-owner's `ret_valid` is 0. In `R_IDLE`, a stray `bus_ret_valid` is dropped.

## Timing
- Reset: both FSMs go to IDLE, `starve_cnt = 0`, `wr_line = 0`.
  - All `*_rdy`, `*_ret_valid`, `*_ret_last`, `bus_rd_req` and `bus_wr_req` are 0.
  - Data and address outputs are don't-care.
- Zero added latency: request and return paths are combinational from registered state. The arbiter adds no pipeline stage.
- A new read may be granted in the cycle after the final-beat cycle, not in the final-beat cycle itself.
- The write may complete in the same cycle as a read handshake. A read masked by `W_BUSY` becomes eligible in the cycle after `bus_wr_done`.
- Requesters hold `req`, `type` and `addr` stable until their `rdy`. The arbiter never retracts a grant once `bus_rd_req` is issued for that requester.
- Reset asserted mid-burst abandons the transaction. The bridge shares `rst`.

## Structure
- State enums (`rd_arb_state_t`, `wr_arb_state_t`) and the `rd_type` encoding constants go in `core_config`.
- No sub-module is needed. Both FSMs, the starvation counter and the line comparator live in one file (about 200 lines).

## Test plan
- Only `ic_rd_req`, line read at 0x1C00_0040 → `bus_rd_addr = 0x1C00_0040`. Four beats routed to `ic_ret_*` only; `ic_ret_last` on beat 4; FSM back to `R_IDLE`.
- Both read requests each cycle with `bus_rd_rdy` held 1 → 4 dcache grants, then 1 icache grant, then the dcache pattern repeats.
- Write to 0x0000_1000 handshaked and `bus_wr_done` delayed 10 cycles; dcache read at 0x0000_100C → no `bus_rd_req` until the cycle after `bus_wr_done`. An icache read to 0x0000_2000 in the same window is granted immediately.
- Write handshake and dcache read to the same line in the same cycle → read blocked; different line → both handshake that cycle.
- `rst` pulsed on beat 2 of a dcache refill → next cycle all outputs are 0; a subsequent icache read is granted normally.
